addsub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor with a start/busy/done handshake and registered status flags.
- Generalises the 4-bit combinational add/sub unit to WIDTH bits.
- Processes DIGIT bits per clock through a single DIGIT-bit slice adder, trading latency for area.
- Used wherever the datapath needs add/sub plus carry, overflow and zero flags without a full-width adder.

---
 rtl/addsub_serial.sv | 130 +++++++++++++
 tb/tb_addsub_serial.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice per clock, start/busy/done handshake.
// Optional saturation on signed overflow when ADDSUB_SERIAL_SAT_EN is defined.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               cy_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               carry_reg;
  logic               overflow_reg;
  logic               zero_reg;

  logic [DIGIT:0]     c_chain;
  logic [DIGIT-1:0]   sum_digit;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   result_next;
  logic               overflow_next;

  // Ripple chain through the single DIGIT-bit slice.
  assign c_chain[0] = cy_reg;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      assign sum_digit[gi]   = a_reg[gi] ^ b_reg[gi] ^ c_chain[gi];
      assign c_chain[gi + 1] = (a_reg[gi] & b_reg[gi]) | (c_chain[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  // New digit enters at the top; on the last digit this is the complete sum.
  assign acc_next      = WIDTH'({sum_digit, acc_reg} >> DIGIT);
  assign overflow_next = c_chain[DIGIT] ^ c_chain[DIGIT-1];

`ifdef ADDSUB_SERIAL_SAT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
  // A wrapped sign bit of 1 on overflow means the true value was positive.
  assign result_next = overflow_next ? (acc_next[WIDTH-1] ? MAX_POS : MIN_NEG) : acc_next;
`else
  assign result_next = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      cy_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= operand_a;
            b_reg     <= mode ? ~operand_b : operand_b;
            cy_reg    <= mode;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> DIGIT;
          b_reg   <= b_reg >> DIGIT;
          acc_reg <= acc_next;
          cy_reg  <= c_chain[DIGIT];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_DIGIT) begin
            result_reg   <= result_next;
            carry_reg    <= c_chain[DIGIT];
            overflow_reg <= overflow_next;
            zero_reg     <= (result_next == '0);
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: WIDTH=8/DIGIT=2 main instance plus a WIDTH=4/DIGIT=4 degenerate instance.
module tb_addsub_serial;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, mode;
  logic [7:0] operand_a, operand_b;
  logic       busy, done, carry, overflow, zero;
  logic [7:0] result;

  logic       start4, mode4;
  logic [3:0] operand_a4, operand_b4;
  logic       busy4, done4, carry4, overflow4, zero4;
  logic [3:0] result4;

  int tests_run    = 0;
  int tests_failed = 0;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  addsub_serial #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode4),
    .operand_a(operand_a4), .operand_b(operand_b4),
    .busy(busy4), .done(done4), .result(result4),
    .carry(carry4), .overflow(overflow4), .zero(zero4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after the budget).
  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) return;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_r, input logic exp_c, input logic exp_v, input logic exp_z);
    int bc;
    @(negedge clk);
    start = 1'b1; mode = m; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check({name, "_busy_cycles"}, bc, 32'd4);
    check({name, "_result"}, {24'b0, result}, {24'b0, exp_r});
    check({name, "_carry"}, {31'b0, carry}, {31'b0, exp_c});
    check({name, "_overflow"}, {31'b0, overflow}, {31'b0, exp_v});
    check({name, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
    $display("[TB] %s: a=%h b=%h mode=%0d -> result=%h c=%b v=%b z=%b busy_cycles=%0d",
             name, a, b, m, result, carry, overflow, zero, bc);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int  bc;
    bit  seen_done;

    reset = 1'b1; start = 1'b0; mode = 1'b0; operand_a = '0; operand_b = '0;
    start4 = 1'b0; mode4 = 1'b0; operand_a4 = '0; operand_b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", {24'b0, result}, 32'd0);
    check("reset_flags", {29'b0, carry, overflow, zero}, 32'd0);
    check("reset_busy4", {31'b0, busy4}, 32'd0);

    run_op("add", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op("sub_zero", 1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_SERIAL_SAT_EN
    run_op("ovf", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0);
`else
    run_op("ovf", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
`endif
    run_op("borrow", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("add_carry", 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);

    // Start during busy must be ignored.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; operand_a = 8'h35; operand_b = 8'h4A;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; operand_a = 8'h01; operand_b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("busy_start_result", {24'b0, result}, 32'h7F);
    $display("[TB] ignored_start: result=%h", result);

    // Start in the done cycle is accepted.
    start = 1'b1; operand_a = 8'h01; operand_b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done(bc);
    check("b2b_busy_cycles", bc, 32'd4);
    check("b2b_result", {24'b0, result}, 32'h02);
    $display("[TB] back_to_back: result=%h busy_cycles=%0d", result, bc);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; operand_a = 8'h7F; operand_b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", {24'b0, result}, 32'd0);
    check("abort_flags", {29'b0, carry, overflow, zero}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);
    $display("[TB] reset_abort: busy=%b result=%h seen_done=%b", busy, result, seen_done);

    // Degenerate N=1: 4'h9 - 4'h3.
    @(negedge clk);
    start4 = 1'b1; mode4 = 1'b1; operand_a4 = 4'h9; operand_b4 = 4'h3;
    @(negedge clk);
    start4 = 1'b0;
    check("deg_busy", {31'b0, busy4}, 32'd1);
    check("deg_done_early", {31'b0, done4}, 32'd0);
    @(negedge clk);
    check("deg_done", {31'b0, done4}, 32'd1);
    check("deg_result", {28'b0, result4}, 32'h6);
    check("deg_flags", {29'b0, carry4, overflow4, zero4}, 32'b110);
    $display("[TB] degenerate: result=%h c=%b v=%b z=%b", result4, carry4, overflow4, zero4);
    @(negedge clk);
    check("deg_done_pulse", {31'b0, done4}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
